// File: rtl/wrr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wrr_arbiter
// Purpose  : Weighted round-robin arbiter with ack handshake. Shares one
//            downstream resource among WIDTH requesters; requester i receives
//            up to weight[i] acknowledged grants per round, and credits are
//            refilled from the weights input in a dedicated RELOAD state.
// Ports    : clk          - clock, rising edge
//            resetb       - asynchronous active-low reset
//            request      - per-requester request vector
//            ack          - resource done with current grant (pulse)
//            weights      - packed weights, req i at [i*WEIGHT_W +: WEIGHT_W]
//            grant        - registered one-hot grant
//            grant_valid  - registered |grant
//            grant_id     - registered index of granted requester (0 if idle)
// Revision : 1.0 - initial release
// ============================================================================
module wrr_arbiter #(
   parameter int WIDTH    = 4,
   parameter int WEIGHT_W = 4
) (
   input  logic                      clk,
   input  logic                      resetb,
   input  logic [WIDTH-1:0]          request,
   input  logic                      ack,
   input  logic [WIDTH*WEIGHT_W-1:0] weights,
   output logic [WIDTH-1:0]          grant,
   output logic                      grant_valid,
   output logic [$clog2(WIDTH)-1:0]  grant_id
);

   localparam int ID_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RELOAD = 2'd1,
      ST_GRANT  = 2'd2
   } state_t;

   state_t              state_q;
   logic [WEIGHT_W-1:0] credit_q [WIDTH];
   logic [ID_W-1:0]     ptr_q;
   logic [WIDTH-1:0]    grant_q;
   logic                grant_valid_q;
   logic [ID_W-1:0]     grant_id_q;

   logic [WEIGHT_W-1:0] weight [WIDTH];
   logic [WIDTH-1:0]    eligible;
   logic                any_eligible;
   logic                win_found;
   logic [ID_W-1:0]     win_idx;
   logic [ID_W-1:0]     gnt_next_id;

   // Unpack weights; a zero weight masks the requester entirely.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_unpack
      assign weight[gi]   = weights[gi*WEIGHT_W +: WEIGHT_W];
      assign eligible[gi] = request[gi] && (weight[gi] != '0);
   end

   assign any_eligible = |eligible;

   // Rotating scan starting at ptr_q: first eligible requester that still
   // has credit in the current round wins.
   always_comb begin
      logic [ID_W:0]   sum;
      logic [ID_W-1:0] idx;
      win_found = 1'b0;
      win_idx   = '0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < WIDTH; k++) begin
         sum = {1'b0, ptr_q} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(WIDTH)) begin
            sum = sum - (ID_W+1)'(WIDTH);
         end
         idx = sum[ID_W-1:0];
         if (!win_found && eligible[idx] && (credit_q[idx] != '0)) begin
            win_found = 1'b1;
            win_idx   = idx;
         end
      end
   end

   // Requester after the current holder, wrapping at WIDTH.
   assign gnt_next_id = (grant_id_q == ID_W'(WIDTH-1)) ? '0 : grant_id_q + ID_W'(1);

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            credit_q[i] <= '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (win_found) begin
                  grant_q       <= WIDTH'(1) << win_idx;
                  grant_valid_q <= 1'b1;
                  grant_id_q    <= win_idx;
                  state_q       <= ST_GRANT;
               end else if (any_eligible) begin
                  // Someone wants service but the round is exhausted.
                  state_q <= ST_RELOAD;
               end
            end

            ST_RELOAD: begin
               // Only place weights are sampled into credits.
               for (int i = 0; i < WIDTH; i++) begin
                  credit_q[i] <= weight[i];
               end
               state_q <= ST_IDLE;
            end

            ST_GRANT: begin
               if (ack) begin
                  // Ack wins even if the request drops in the same cycle.
                  credit_q[grant_id_q] <= credit_q[grant_id_q] - WEIGHT_W'(1);
                  // Keep the pointer on the holder until its credit runs out.
                  ptr_q <= (credit_q[grant_id_q] == WEIGHT_W'(1)) ? gnt_next_id
                                                                    : grant_id_q;
                  grant_q       <= '0;
                  grant_valid_q <= 1'b0;
                  grant_id_q    <= '0;
                  state_q       <= ST_IDLE;
               end else if (!request[grant_id_q]) begin
                  // Abort: no credit consumed, move past the holder.
                  ptr_q         <= gnt_next_id;
                  grant_q       <= '0;
                  grant_valid_q <= 1'b0;
                  grant_id_q    <= '0;
                  state_q       <= ST_IDLE;
               end
            end

            default: begin
               grant_q       <= '0;
               grant_valid_q <= 1'b0;
               grant_id_q    <= '0;
               state_q       <= ST_IDLE;
            end
         endcase
      end
   end

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;

endmodule
`default_nettype wire
